// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Registered, handshaked ALU-control decoder placed between decode and execute.
//   It decodes R-type, OP-IMM and M-extension ops into an ALU ctrl code. Each op
//   is held for its execute latency and then presented with a valid/ready
//   handshake. Upstream is stalled while a multi-cycle MUL/DIV op is in flight.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active-low
//   flush_i      synchronous kill of the in-flight or held op
//   in_valid_i   upstream op valid
//   in_ready_o   op can be accepted this cycle
//   opcode_i     instr[6:0]
//   funct3_i     instr[14:12]
//   funct7_i     instr[31:25]
//   out_valid_o  ctrl/is_imm/illegal are valid
//   out_ready_i  downstream consumes the result
//   ctrl_o       ALU op code
//   is_imm_o     op is OP-IMM (operand B is the immediate)
//   illegal_o    unsupported opcode/funct combination
//   busy_o       multi-cycle op counting
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing held, ready to accept
// WAIT  | multi-cycle op counting down its latency, upstream stalled
// DONE  | result presented, held until out_ready_i

module alu_op_sequencer #(
  parameter int CTRL_W   = 5,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 33,
  parameter int ENABLE_M = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              is_imm_o,
  output logic              illegal_o,
  output logic              busy_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] CLS_ONE = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_DIV = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              imm_q, imm_d;
  logic              ill_q, ill_d;

  logic [4:0]        dec_code;
  logic              dec_imm;
  logic              dec_ill;
  logic [1:0]        dec_cls;
  logic              dec_multi;
  logic [CNT_W-1:0]  dec_load;
  logic              accept;

  // Combinational decode of the presented instruction fields.
  always_comb begin
    dec_code = 5'd0;
    dec_imm  = 1'b0;
    dec_ill  = 1'b1;
    dec_cls  = CLS_ONE;
    if (opcode_i == OPC_OP) begin
      if (funct7_i == F7_BASE) begin
        dec_ill = 1'b0;
        case (funct3_i)
          3'b000:  dec_code = 5'd0;
          3'b001:  dec_code = 5'd5;
          3'b010:  dec_code = 5'd8;
          3'b011:  dec_code = 5'd9;
          3'b100:  dec_code = 5'd4;
          3'b101:  dec_code = 5'd6;
          3'b110:  dec_code = 5'd3;
          default: dec_code = 5'd2;
        endcase
      end else if (funct7_i == F7_ALT) begin
        if (funct3_i == 3'b000) begin
          dec_ill  = 1'b0;
          dec_code = 5'd1;
        end else if (funct3_i == 3'b101) begin
          dec_ill  = 1'b0;
          dec_code = 5'd7;
        end
      end else if ((funct7_i == F7_MULDIV) && (ENABLE_M != 0)) begin
        dec_ill = 1'b0;
        dec_cls = funct3_i[2] ? CLS_DIV : CLS_MUL;
        case (funct3_i)
          3'b000:  dec_code = 5'd10;
          3'b001:  dec_code = 5'd11;
          3'b010:  dec_code = 5'd13;
          3'b011:  dec_code = 5'd12;
          3'b100:  dec_code = 5'd14;
          3'b101:  dec_code = 5'd15;
          3'b110:  dec_code = 5'd16;
          default: dec_code = 5'd17;
        endcase
      end
    end else if (opcode_i == OPC_OP_IMM) begin
      // funct7 only qualifies the shifts; elsewhere those bits are immediate.
      dec_ill = 1'b0;
      dec_imm = 1'b1;
      case (funct3_i)
        3'b000: dec_code = 5'd0;
        3'b010: dec_code = 5'd8;
        3'b011: dec_code = 5'd9;
        3'b100: dec_code = 5'd4;
        3'b110: dec_code = 5'd3;
        3'b111: dec_code = 5'd2;
        3'b001: begin
          if (funct7_i == F7_BASE) begin
            dec_code = 5'd5;
          end else begin
            dec_ill = 1'b1;
            dec_imm = 1'b0;
          end
        end
        default: begin
          if (funct7_i == F7_BASE) begin
            dec_code = 5'd6;
          end else if (funct7_i == F7_ALT) begin
            dec_code = 5'd7;
          end else begin
            dec_ill = 1'b1;
            dec_imm = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    dec_multi = 1'b0;
    dec_load  = '0;
    if (dec_cls == CLS_MUL) begin
      dec_multi = (MUL_LAT > 1);
      dec_load  = CNT_W'(MUL_LAT - 1);
    end else if (dec_cls == CLS_DIV) begin
      dec_multi = (DIV_LAT > 1);
      dec_load  = CNT_W'(DIV_LAT - 1);
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_WAIT);
  assign ctrl_o      = ctrl_q;
  assign is_imm_o    = imm_q;
  assign illegal_o   = ill_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    ill_d   = ill_q;
    if (flush_i) begin
      // Flush kills the handshake but leaves the last decoded fields visible.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: if (out_ready_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // Accept in DONE overrides the return to IDLE: back-to-back with no bubble.
      if (accept) begin
        ctrl_d = CTRL_W'(dec_code);
        imm_d  = dec_imm;
        ill_d  = dec_ill;
        if (dec_multi) begin
          state_d = ST_WAIT;
          cnt_d   = dec_load;
        end else begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      imm_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer: a decode/latency vector table plus
//   hand-written sequences for streaming, backpressure, flush and reset.
//   A second instance with the M extension disabled covers the illegal-M path.

module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic       in_ready, out_valid, is_imm, illegal, busy;
  logic [4:0] ctrl;
  logic       nm_in_ready, nm_out_valid, nm_is_imm, nm_illegal, nm_busy;
  logic [4:0] nm_ctrl;

  int n_checks = 0;
  int n_err    = 0;

  alu_op_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ctrl_o(ctrl), .is_imm_o(is_imm), .illegal_o(illegal), .busy_o(busy)
  );

  alu_op_sequencer #(.ENABLE_M(0)) dut_nm (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(nm_in_ready),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .out_valid_o(nm_out_valid), .out_ready_i(out_ready),
    .ctrl_o(nm_ctrl), .is_imm_o(nm_is_imm), .illegal_o(nm_illegal), .busy_o(nm_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         ctrl;
    int         imm;
    int         ill;
    int         lat;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input int c, input int im, input int il, input int lat);
    vecs[nv] = '{op, f3, f7, c, im, il, lat};
    nv++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Runs one op from IDLE with out_ready=1 and checks latency and decoded fields.
  task automatic run_op(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input int ec, input int ei, input int el,
                        input int lat);
    int k;
    drive(op, f3, f7);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({nm, "_in_ready_idle"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 50) begin
      chk({nm, "_busy_stall"}, int'({busy, in_ready}), 2);
      tick();
      k++;
    end
    chk({nm, "_out_valid"}, int'(out_valid), 1);
    chk({nm, "_latency"}, k, lat);
    chk({nm, "_ctrl"}, int'(ctrl), ec);
    chk({nm, "_is_imm"}, int'(is_imm), ei);
    chk({nm, "_illegal"}, int'(illegal), el);
    tick();
    chk({nm, "_back_idle"}, int'(out_valid), 0);
  endtask

  initial begin
    int k;
    int seen;
    int exp_c[4];
    int exp_i[4];

    add(R, 3'b000, 7'b0000000,  0, 0, 0, 1);
    add(R, 3'b000, 7'b0100000,  1, 0, 0, 1);
    add(R, 3'b111, 7'b0000000,  2, 0, 0, 1);
    add(R, 3'b110, 7'b0000000,  3, 0, 0, 1);
    add(R, 3'b100, 7'b0000000,  4, 0, 0, 1);
    add(R, 3'b001, 7'b0000000,  5, 0, 0, 1);
    add(R, 3'b101, 7'b0000000,  6, 0, 0, 1);
    add(R, 3'b101, 7'b0100000,  7, 0, 0, 1);
    add(R, 3'b010, 7'b0000000,  8, 0, 0, 1);
    add(R, 3'b011, 7'b0000000,  9, 0, 0, 1);
    add(R, 3'b000, 7'b0000001, 10, 0, 0, 2);
    add(R, 3'b001, 7'b0000001, 11, 0, 0, 2);
    add(R, 3'b011, 7'b0000001, 12, 0, 0, 2);
    add(R, 3'b010, 7'b0000001, 13, 0, 0, 2);
    add(R, 3'b100, 7'b0000001, 14, 0, 0, 33);
    add(R, 3'b101, 7'b0000001, 15, 0, 0, 33);
    add(R, 3'b110, 7'b0000001, 16, 0, 0, 33);
    add(R, 3'b111, 7'b0000001, 17, 0, 0, 33);
    add(I, 3'b000, 7'b0000000,  0, 1, 0, 1);
    add(I, 3'b010, 7'b0000000,  8, 1, 0, 1);
    add(I, 3'b011, 7'b1111111,  9, 1, 0, 1);
    add(I, 3'b100, 7'b0000000,  4, 1, 0, 1);
    add(I, 3'b110, 7'b0000000,  3, 1, 0, 1);
    add(I, 3'b111, 7'b0101010,  2, 1, 0, 1);
    add(I, 3'b001, 7'b0000000,  5, 1, 0, 1);
    add(I, 3'b101, 7'b0000000,  6, 1, 0, 1);
    add(I, 3'b101, 7'b0100000,  7, 1, 0, 1);
    add(I, 3'b101, 7'b0100001,  0, 0, 1, 1);
    add(I, 3'b001, 7'b0100000,  0, 0, 1, 1);
    add(R, 3'b001, 7'b0100000,  0, 0, 1, 1);
    add(R, 3'b000, 7'b0000010,  0, 0, 1, 1);
    add(7'b0000011, 3'b000, 7'b0000000, 0, 0, 1, 1);

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(7'd0, 3'd0, 7'd0);
    #2 rst_n = 1'b0;
    #20;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ctrl", int'(ctrl), 0);
    chk("rst_flags", int'({is_imm, illegal, busy}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", int'(in_ready), 1);

    // Decode/latency table.
    for (int i = 0; i < nv; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].f7,
             vecs[i].ctrl, vecs[i].imm, vecs[i].ill, vecs[i].lat);
    end

    // Stream of four single-cycle ops: four consecutive valid cycles, no bubble.
    exp_c = '{0, 1, 4, 0};
    exp_i = '{0, 0, 0, 1};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(R, 3'b000, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stream%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("stream%0d_ctrl", i), int'(ctrl), exp_c[i]);
      chk($sformatf("stream%0d_imm", i), int'(is_imm), exp_i[i]);
      chk($sformatf("stream%0d_in_ready", i), int'(in_ready), 1);
      case (i)
        0: drive(R, 3'b000, 7'b0100000);
        1: drive(R, 3'b100, 7'b0000000);
        2: drive(I, 3'b000, 7'b0000000);
        default: in_valid = 1'b0;
      endcase
    end
    tick();
    chk("stream_end_valid", int'(out_valid), 0);

    // MULHSU under backpressure: result held, upstream stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(R, 3'b010, 7'b0000001);
    tick();
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    chk("bp_latency", k, 2);
    in_valid = 1'b1;
    drive(R, 3'b000, 7'b0000000);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("bp_hold%0d_ctrl", i), int'(ctrl), 13);
      chk($sformatf("bp_hold%0d_in_ready", i), int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_ctrl", int'(ctrl), 0);
    tick();
    chk("bp_next_idle", int'(out_valid), 0);

    // REM flushed at N+10: no output, ready at N+11, fields kept.
    in_valid = 1'b1;
    drive(R, 3'b110, 7'b0000001);
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", int'(in_ready), 1);
    chk("flush_busy", int'(busy), 0);
    chk("flush_ctrl_kept", int'(ctrl), 16);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    chk("flush_no_valid", seen, 0);
    run_op("post_flush_add", R, 3'b000, 7'b0000000, 0, 0, 0, 1);

    // M disabled: MUL is a single-cycle illegal op on the second instance.
    in_valid = 1'b1;
    drive(R, 3'b000, 7'b0000001);
    tick();
    in_valid = 1'b0;
    chk("nm_mul_valid", int'(nm_out_valid), 1);
    chk("nm_mul_ctrl", int'(nm_ctrl), 0);
    chk("nm_mul_illegal", int'(nm_illegal), 1);
    chk("nm_mul_imm", int'(nm_is_imm), 0);
    chk("m_mul_busy", int'(busy), 1);
    k = 0;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    chk("m_mul_done", int'(out_valid), 1);
    tick();

    // Reset asserted mid-DIV: outputs clear before any clock edge.
    in_valid = 1'b1;
    drive(R, 3'b100, 7'b0000001);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("div_busy_before_rst", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_ctrl", int'(ctrl), 0);
    chk("rst_mid_flags", int'({is_imm, illegal, busy}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("rst_mid_no_valid", seen, 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
